rsv_stable_issue: RTL and testbench

Reservation-station issue controller for stable execution pipes. It sits directly upstream of the stable-pipe scoreboard and buffers dispatched micro-ops. It tracks source-operand readiness from the writeback broadcast, picks the oldest ready entry, and asks the scoreboard whether that entry's target pipe can take it. When the scoreboard says yes, it issues the entry to the pipe and raises the scoreboard tracking request in the same cycle.

---
 rtl/rsv_stable_issue_if.sv | 44 ++++
 rtl/rsv_stable_issue.sv | 112 +++++++++++
 tb/tb_rsv_stable_issue.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/rsv_stable_issue_if.sv
// rtl/rsv_stable_issue_if.sv - dispatch, wakeup, scoreboard and issue signals of the stable-pipe reservation station
interface rsv_stable_issue_if #(
  parameter int DEPTH     = 4,
  parameter int PIP_BITS  = 3,
  parameter int PREG_BITS = 6,
  parameter int PAYLOAD_W = 32
);
  logic                         disp_valid;
  logic                         disp_ready;
  logic [PIP_BITS-1:0]          disp_pipe;
  logic [PREG_BITS-1:0]         disp_rs1;
  logic [PREG_BITS-1:0]         disp_rs2;
  logic                         disp_rs1_rdy;
  logic                         disp_rs2_rdy;
  logic [PREG_BITS-1:0]         disp_rd;
  logic [PAYLOAD_W-1:0]         disp_payload;
  logic                         wb_valid;
  logic [PREG_BITS-1:0]         wb_preg;
  logic [PIP_BITS-1:0]          scb_search_pip;
  logic                         scb_available;
  logic                         scb_req;
  logic                         iss_valid;
  logic                         iss_ready;
  logic [PIP_BITS-1:0]          iss_pipe;
  logic [PREG_BITS-1:0]         iss_rd;
  logic [PAYLOAD_W-1:0]         iss_payload;
  logic                         flush;
  logic [$clog2(DEPTH+1)-1:0]   occupancy;

  // master is the surrounding pipeline; slave is the station itself
  modport master (
    output disp_valid, disp_pipe, disp_rs1, disp_rs2, disp_rs1_rdy, disp_rs2_rdy,
           disp_rd, disp_payload, wb_valid, wb_preg, scb_available, iss_ready, flush,
    input  disp_ready, scb_search_pip, scb_req, iss_valid, iss_pipe, iss_rd,
           iss_payload, occupancy
  );

  modport slave (
    input  disp_valid, disp_pipe, disp_rs1, disp_rs2, disp_rs1_rdy, disp_rs2_rdy,
           disp_rd, disp_payload, wb_valid, wb_preg, scb_available, iss_ready, flush,
    output disp_ready, scb_search_pip, scb_req, iss_valid, iss_pipe, iss_rd,
           iss_payload, occupancy
  );
endinterface

// File: rtl/rsv_stable_issue.sv
// rtl/rsv_stable_issue.sv - collapsing-queue reservation station issuing oldest ready micro-op to a stable pipe
module rsv_stable_issue #(
  parameter logic [2:0] RSV_ID    = 3'b0,
  parameter int         DEPTH     = 4,
  parameter int         PIP_BITS  = 3,
  parameter int         PREG_BITS = 6,
  parameter int         PAYLOAD_W = 32
) (
  input logic               clk,
  input logic               rst,
  rsv_stable_issue_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  if (DEPTH < 2 || DEPTH > 16 || $bits(RSV_ID) != 3) begin : g_param_check
    $error("rsv_stable_issue: DEPTH must be 2..16");
  end

  typedef struct packed {
    logic [PIP_BITS-1:0]  pipe;
    logic [PREG_BITS-1:0] rs1;
    logic                 rs1_rdy;
    logic [PREG_BITS-1:0] rs2;
    logic                 rs2_rdy;
    logic [PREG_BITS-1:0] rd;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t           q   [DEPTH];
  entry_t           q_n [DEPTH];
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_n;
  logic [CNT_W-1:0] sel;
  logic [CNT_W-1:0] wr_idx;
  entry_t           sel_e;
  entry_t           new_e;
  logic             found;
  logic             fire;
  logic             accept;

  // Oldest ready entry wins: scan from the top so the lowest index is assigned last
  always_comb begin
    found = 1'b0;
    sel   = '0;
    sel_e = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (CNT_W'(i) < count && q[i].rs1_rdy && q[i].rs2_rdy) begin
        found = 1'b1;
        sel   = CNT_W'(i);
        sel_e = q[i];
      end
    end
  end

  assign bus.scb_search_pip = found ? sel_e.pipe : '0;
  assign bus.iss_valid      = found & bus.scb_available & ~bus.flush;
  assign bus.iss_pipe       = bus.iss_valid ? sel_e.pipe    : '0;
  assign bus.iss_rd         = bus.iss_valid ? sel_e.rd      : '0;
  assign bus.iss_payload    = bus.iss_valid ? sel_e.payload : '0;
  assign fire               = bus.iss_valid & bus.iss_ready;
  assign bus.scb_req        = fire;
  assign bus.disp_ready     = (count < CNT_W'(DEPTH)) & ~bus.flush & ~rst;
  assign accept             = bus.disp_valid & bus.disp_ready;
  assign bus.occupancy      = count;
  assign wr_idx             = count - CNT_W'(fire);

  // Incoming entry snoops the same-cycle broadcast so it is not left waiting forever
  always_comb begin
    new_e         = '0;
    new_e.pipe    = bus.disp_pipe;
    new_e.rs1     = bus.disp_rs1;
    new_e.rs2     = bus.disp_rs2;
    new_e.rd      = bus.disp_rd;
    new_e.payload = bus.disp_payload;
    new_e.rs1_rdy = bus.disp_rs1_rdy | (bus.wb_valid & (bus.wb_preg == bus.disp_rs1));
    new_e.rs2_rdy = bus.disp_rs2_rdy | (bus.wb_valid & (bus.wb_preg == bus.disp_rs2));
  end

  always_comb begin
    q_n     = q;
    count_n = count + CNT_W'(accept) - CNT_W'(fire);
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.wb_valid && CNT_W'(i) < count) begin
        if (q[i].rs1 == bus.wb_preg) q_n[i].rs1_rdy = 1'b1;
        if (q[i].rs2 == bus.wb_preg) q_n[i].rs2_rdy = 1'b1;
      end
    end
    if (fire) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (CNT_W'(i) >= sel) q_n[i] = q_n[i + 1];
      end
      q_n[DEPTH - 1] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (accept && CNT_W'(i) == wr_idx) q_n[i] = new_e;
    end
    if (bus.flush) begin
      count_n = '0;
      for (int i = 0; i < DEPTH; i++) q_n[i] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      count <= count_n;
      q     <= q_n;
    end
  end
endmodule

// File: tb/tb_rsv_stable_issue.sv
// tb/tb_rsv_stable_issue.sv - directed self-checking bench for rsv_stable_issue
module tb_rsv_stable_issue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  rsv_stable_issue_if #(.DEPTH(4), .PIP_BITS(3), .PREG_BITS(6), .PAYLOAD_W(32)) bus ();

  rsv_stable_issue #(
    .RSV_ID(3'b0), .DEPTH(4), .PIP_BITS(3), .PREG_BITS(6), .PAYLOAD_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one edge, then let inputs change 2ns later, checks happen after a further settle
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.disp_valid = 0; bus.disp_pipe = 0; bus.disp_rs1 = 0; bus.disp_rs2 = 0;
    bus.disp_rs1_rdy = 0; bus.disp_rs2_rdy = 0; bus.disp_rd = 0; bus.disp_payload = 0;
    bus.wb_valid = 0; bus.wb_preg = 0; bus.flush = 0;
  endtask

  task automatic disp(input logic [2:0] pipe, input logic [5:0] rs1, input logic r1,
                      input logic [5:0] rs2, input logic r2, input logic [5:0] rd,
                      input logic [31:0] pl);
    bus.disp_valid = 1; bus.disp_pipe = pipe; bus.disp_rs1 = rs1; bus.disp_rs1_rdy = r1;
    bus.disp_rs2 = rs2; bus.disp_rs2_rdy = r2; bus.disp_rd = rd; bus.disp_payload = pl;
  endtask

  initial begin
    idle_inputs();
    bus.scb_available = 0;
    bus.iss_ready = 0;

    // reset held for two cycles
    tick(); tick(); #1;
    chk("rst_occ", 32'(bus.occupancy), 0);
    chk("rst_iss_valid", 32'(bus.iss_valid), 0);
    chk("rst_scb_req", 32'(bus.scb_req), 0);
    chk("rst_disp_ready", 32'(bus.disp_ready), 0);
    chk("rst_search_pip", 32'(bus.scb_search_pip), 0);
    rst = 0; #1;
    chk("post_rst_disp_ready", 32'(bus.disp_ready), 1);

    // single ready dispatch issues next cycle
    tick();
    bus.scb_available = 1; bus.iss_ready = 1;
    disp(3'd2, 6'd1, 1, 6'd2, 1, 6'd5, 32'hCAFE0001); #1;
    chk("empty_iss_valid", 32'(bus.iss_valid), 0);
    tick(); idle_inputs(); #1;
    chk("t2_occ1", 32'(bus.occupancy), 1);
    chk("t2_search_pip", 32'(bus.scb_search_pip), 2);
    chk("t2_iss_valid", 32'(bus.iss_valid), 1);
    chk("t2_iss_rd", 32'(bus.iss_rd), 5);
    chk("t2_iss_payload", bus.iss_payload, 32'hCAFE0001);
    chk("t2_scb_req", 32'(bus.scb_req), 1);
    tick(); #1;
    chk("t2_occ0", 32'(bus.occupancy), 0);
    chk("t2_drained", 32'(bus.iss_valid), 0);

    // younger ready entry bypasses older waiting one; wakeup visible one cycle later
    disp(3'd1, 6'd7, 0, 6'd3, 1, 6'd10, 32'hAAAA0000);
    tick();
    disp(3'd3, 6'd4, 1, 6'd5, 1, 6'd11, 32'hBBBB0000); #1;
    chk("t3_a_not_ready", 32'(bus.iss_valid), 0);
    chk("t3_a_search_pip", 32'(bus.scb_search_pip), 0);
    tick(); idle_inputs(); #1;
    chk("t3_occ2", 32'(bus.occupancy), 2);
    chk("t3_b_first", 32'(bus.iss_rd), 11);
    chk("t3_b_pipe", 32'(bus.iss_pipe), 3);
    tick();
    bus.wb_valid = 1; bus.wb_preg = 6'd7; #1;
    chk("t3_occ1", 32'(bus.occupancy), 1);
    chk("t3_wb_same_cycle", 32'(bus.iss_valid), 0);
    tick(); idle_inputs(); #1;
    chk("t3_a_woken", 32'(bus.iss_valid), 1);
    chk("t3_a_rd", 32'(bus.iss_rd), 10);
    chk("t3_a_payload", bus.iss_payload, 32'hAAAA0000);
    tick(); #1;
    chk("t3_occ0", 32'(bus.occupancy), 0);

    // fill with scoreboard busy, then drain in order with a concurrent dispatch
    bus.scb_available = 0;
    for (int i = 0; i < 4; i++) begin
      disp(3'(4 + i), 6'd1, 1, 6'd2, 1, 6'(20 + i), 32'(i));
      tick();
    end
    disp(3'd0, 6'd1, 1, 6'd2, 1, 6'd40, 32'hDEAD); #1;
    chk("t4_occ_full", 32'(bus.occupancy), 4);
    chk("t4_disp_ready", 32'(bus.disp_ready), 0);
    chk("t4_iss_valid", 32'(bus.iss_valid), 0);
    chk("t4_scb_req", 32'(bus.scb_req), 0);
    chk("t4_search_pip", 32'(bus.scb_search_pip), 4);
    tick(); idle_inputs(); #1;
    chk("t4_full_no_accept", 32'(bus.occupancy), 4);
    bus.scb_available = 1; #1;
    chk("t4_iss0", 32'(bus.iss_rd), 20);
    chk("t4_disp_ready_full_fire", 32'(bus.disp_ready), 0);
    tick(); #1;
    chk("t4_occ3", 32'(bus.occupancy), 3);
    chk("t4_iss1", 32'(bus.iss_rd), 21);
    chk("t4_pip1", 32'(bus.scb_search_pip), 5);
    disp(3'd1, 6'd1, 1, 6'd2, 1, 6'd30, 32'h30);
    tick(); idle_inputs(); #1;
    chk("t4_fire_disp_occ", 32'(bus.occupancy), 3);
    chk("t4_iss2", 32'(bus.iss_rd), 22);
    tick(); #1;
    chk("t4_iss3", 32'(bus.iss_rd), 23);
    tick(); #1;
    chk("t4_iss_new", 32'(bus.iss_rd), 30);
    chk("t4_iss_new_pipe", 32'(bus.iss_pipe), 1);
    tick(); #1;
    chk("t4_occ0", 32'(bus.occupancy), 0);

    // dispatch snoops a same-cycle broadcast
    disp(3'd6, 6'd9, 0, 6'd2, 1, 6'd12, 32'h12);
    bus.wb_valid = 1; bus.wb_preg = 6'd9;
    tick(); idle_inputs(); #1;
    chk("t5_snoop_valid", 32'(bus.iss_valid), 1);
    chk("t5_snoop_rd", 32'(bus.iss_rd), 12);
    tick(); #1;
    chk("t5_occ0", 32'(bus.occupancy), 0);

    // flush beats dispatch and fire
    bus.scb_available = 0;
    for (int i = 0; i < 3; i++) begin
      disp(3'd2, 6'd1, 1, 6'd2, 1, 6'(50 + i), 32'(i));
      tick();
    end
    disp(3'd2, 6'd1, 1, 6'd2, 1, 6'd60, 32'h60);
    bus.scb_available = 1; bus.flush = 1; #1;
    chk("t6_occ3", 32'(bus.occupancy), 3);
    chk("t6_flush_iss_valid", 32'(bus.iss_valid), 0);
    chk("t6_flush_scb_req", 32'(bus.scb_req), 0);
    chk("t6_flush_disp_ready", 32'(bus.disp_ready), 0);
    chk("t6_flush_search_pip", 32'(bus.scb_search_pip), 2);
    tick(); idle_inputs(); #1;
    chk("t6_occ0", 32'(bus.occupancy), 0);
    chk("t6_post_iss_valid", 32'(bus.iss_valid), 0);

    // asynchronous reset mid-operation
    bus.scb_available = 0;
    disp(3'd3, 6'd1, 1, 6'd2, 1, 6'd33, 32'h33);
    tick(); idle_inputs(); #1;
    chk("t7_occ1", 32'(bus.occupancy), 1);
    rst = 1; #1;
    chk("t7_async_occ", 32'(bus.occupancy), 0);
    chk("t7_async_disp_ready", 32'(bus.disp_ready), 0);
    bus.scb_available = 1; #1;
    chk("t7_async_iss_valid", 32'(bus.iss_valid), 0);
    tick(); rst = 0; #1;
    chk("t7_release_ready", 32'(bus.disp_ready), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
